// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types for the data-memory request/response path: the request control
// word, the response record, the length encoding, the responder FSM states,
// and helpers that decode length/offset into byte masks and misalignment.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int N_BITS = 32;

  localparam logic DMEM_RD = 1'b0;
  localparam logic DMEM_WR = 1'b1;

  typedef enum logic [1:0] {
    DMEM_BYTE = 2'b00,
    DMEM_HALF = 2'b01,
    DMEM_WORD = 2'b10
  } dmem_len_e;

  // The fourth length code is not a member of dmem_len_e; requests carrying
  // it are rejected with an error.
  localparam logic [1:0] DMEM_LEN_RSVD = 2'b11;

  typedef struct packed {
    logic       vld;
    logic       mtype;
    logic [1:0] len;
  } dmem_req_ctrl_t;

  typedef struct packed {
    logic              vld;
    logic              mtype;
    logic              err;
    logic [N_BITS-1:0] rdata;
  } dmem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } dmem_state_e;

  // Right-justified byte mask for an access length; reserved length gives 0.
  function automatic logic [3:0] dmem_len_mask(input logic [1:0] len);
    logic [3:0] mask;
    case (len)
      DMEM_BYTE: mask = 4'b0001;
      DMEM_HALF: mask = 4'b0011;
      DMEM_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic dmem_misaligned(input logic [1:0] len,
                                           input logic [1:0] off);
    return ((len == DMEM_HALF) && off[0]) ||
           ((len == DMEM_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the load/store stage (master) and the
// data-memory responder (slave).
//   req_ctrl   : {vld, mtype, len}           master -> slave
//   req_addr   : byte address                master -> slave
//   req_wdata  : right-justified store data  master -> slave
//   req_rdy    : request accepted when vld   slave  -> master
//   resp_vld   : response valid              slave  -> master
//   resp_rdy   : response consumed           master -> slave
//   resp_mtype : echo of request type        slave  -> master
//   resp_err   : request was rejected        slave  -> master
//   resp_rdata : right-justified load data   slave  -> master
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  dmem_req_ctrl_t    req_ctrl;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_rdy;
  logic              resp_vld;
  logic              resp_rdy;
  logic              resp_mtype;
  logic              resp_err;
  logic [N_BITS-1:0] resp_rdata;

  modport master (
    output req_ctrl, req_addr, req_wdata, resp_rdy,
    input  req_rdy, resp_vld, resp_mtype, resp_err, resp_rdata
  );

  modport slave (
    input  req_ctrl, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_vld, resp_mtype, resp_err, resp_rdata
  );

endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for a 32-bit memory word.
//   i_len      : access length code (byte/half/word/reserved)
//   i_off      : byte offset within the word (addr[1:0])
//   i_wdata    : right-justified store data
//   i_rdata    : raw word read from memory
//   o_be       : byte enables positioned at the offset
//   o_wdata    : store data moved onto its byte lanes
//   o_rdata    : load data right-justified and zero-extended to the length
//   o_misalign : access crosses its natural alignment
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_len,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [3:0]  w_mask;
  logic [31:0] w_rdata_shr;

  assign w_mask      = dmem_len_mask(i_len);
  assign o_be        = w_mask << i_off;
  assign o_wdata     = i_wdata << {i_off, 3'b000};
  assign w_rdata_shr = i_rdata >> {i_off, 3'b000};
  assign o_misalign  = dmem_misaligned(i_len, i_off);

  // Keep only the bytes covered by the length; upper bytes read as zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_mask
      assign o_rdata[8*gi +: 8] = w_rdata_shr[8*gi +: 8] & {8{w_mask[gi]}};
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the core's data-memory interface. Takes one request at a
// time, performs a single access on a 1-cycle-latency synchronous SRAM and
// returns a response two cycles after acceptance.
//   clk, rst      : core clock, synchronous active-high reset
//   bus (slave)   : request/response handshake bundle
//   sram_en       : SRAM access strobe (only during the access cycle)
//   sram_we       : SRAM write enable
//   sram_be       : SRAM byte enables
//   sram_addr     : SRAM word address
//   sram_wdata    : lane-positioned write data
//   sram_rdata    : SRAM read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  dmem_responder_if.slave                bus,
  output logic                           sram_en,
  output logic                           sram_we,
  output logic [3:0]                     sram_be,
  output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr,
  output logic [31:0]                    sram_wdata,
  input  logic [31:0]                    sram_rdata
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  dmem_state_e r_state;
  logic              r_mtype;
  logic [1:0]        r_len;
  logic [1:0]        r_off;
  logic [AW-1:0]     r_waddr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_first;
  logic [N_BITS-1:0] r_rdata;

  logic [31:0]   w_rel;
  logic          w_in_range;
  logic          w_req_err;
  logic          w_req_rdy;
  logic          w_accept;
  logic          w_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_lane;
  logic [31:0]   w_rdata_lane;
  logic          w_misalign;
  dmem_resp_t    w_resp;

  // Offset from the SRAM base. An address below the base wraps to a value at
  // least 2^32 - BASE_ADDR, which is never below SPAN for a legal base, so a
  // single unsigned compare covers both ends of the window.
  assign w_rel      = bus.req_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_rel} < SPAN);
  assign w_req_err  = !w_in_range
                    || (bus.req_ctrl.len == DMEM_LEN_RSVD)
                    || dmem_misaligned(bus.req_ctrl.len, bus.req_addr[1:0]);

  // A response completing this cycle frees the responder for a new request.
  assign w_req_rdy = (r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.resp_rdy);
  assign w_accept  = bus.req_ctrl.vld && w_req_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mtype <= 1'b0;
      r_len   <= 2'b00;
      r_off   <= 2'b00;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_first <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          r_first <= 1'b1;
        end
        ST_RESP: begin
          r_first <= 1'b0;
          // The SRAM word is only guaranteed during the first RESP cycle;
          // keep an aligned copy so the response holds under backpressure.
          if (r_first) r_rdata <= w_rdata_lane;
          if (bus.resp_rdy) r_state <= w_accept ? ST_ACCESS : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_mtype <= bus.req_ctrl.mtype;
        r_len   <= bus.req_ctrl.len;
        r_off   <= bus.req_addr[1:0];
        r_waddr <= w_rel[AW+1:2];
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
      end
    end
  end

  dmem_lane_align u_lane (
    .i_len      (r_len),
    .i_off      (r_off),
    .i_wdata    (r_wdata),
    .i_rdata    (sram_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_lane),
    .o_rdata    (w_rdata_lane),
    .o_misalign (w_misalign)
  );

  // Gating on rst keeps a write in its access cycle from reaching the SRAM
  // when reset is sampled at the same edge. The misalign term is redundant
  // with r_err but keeps the strobe safe if the lane logic is reused alone.
  assign w_en       = (r_state == ST_ACCESS) && !rst && !r_err && !w_misalign;
  assign sram_en    = w_en;
  assign sram_we    = w_en && r_mtype;
  assign sram_be    = w_en ? w_be : 4'b0000;
  assign sram_addr  = w_en ? r_waddr : '0;
  assign sram_wdata = w_en ? w_wdata_lane : 32'h0;

  always_comb begin
    w_resp       = '0;
    w_resp.vld   = (r_state == ST_RESP);
    w_resp.mtype = w_resp.vld && r_mtype;
    w_resp.err   = w_resp.vld && r_err;
    if (w_resp.vld && !r_err && (r_mtype == DMEM_RD)) begin
      w_resp.rdata = r_first ? w_rdata_lane : r_rdata;
    end
  end

  assign bus.req_rdy    = w_req_rdy;
  assign bus.resp_vld   = w_resp.vld;
  assign bus.resp_mtype = w_resp.mtype;
  assign bus.resp_err   = w_resp.err;
  assign bus.resp_rdata = w_resp.rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder with a behavioural SRAM model. A vector
// table covers single transactions; hand-written sequences cover
// backpressure with a back-to-back accept and reset during a write access.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_clr;
  logic        sram_en;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] mem [DEPTH];

  int n_checks;
  int n_errors;

  dmem_responder_if u_if ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if.slave),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, 1-cycle read latency, byte-write capable.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        mtype;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        exp_en;
    logic [3:0]  exp_be;
    logic [9:0]  exp_saddr;
    logic [31:0] exp_swdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic mtype, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
    u_if.req_ctrl.vld   = 1'b1;
    u_if.req_ctrl.mtype = mtype;
    u_if.req_ctrl.len   = len;
    u_if.req_addr       = addr;
    u_if.req_wdata      = wdata;
  endtask

  task automatic idle_req();
    u_if.req_ctrl  = '0;
    u_if.req_addr  = 32'h0;
    u_if.req_wdata = 32'h0;
  endtask

  // One transaction with resp_rdy held high: accept, access, response.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive_req(v.mtype, v.len, v.addr, v.wdata);
    #1;
    chk($sformatf("v%0d_req_rdy", idx), 32'(u_if.req_rdy), 32'd1);
    @(negedge clk);
    idle_req();
    chk($sformatf("v%0d_acc_vld", idx), 32'(u_if.resp_vld), 32'd0);
    chk($sformatf("v%0d_sram_en", idx), 32'(sram_en), 32'(v.exp_en));
    if (v.exp_en) begin
      chk($sformatf("v%0d_sram_we", idx), 32'(sram_we), 32'(v.mtype));
      chk($sformatf("v%0d_sram_be", idx), 32'(sram_be), 32'(v.exp_be));
      chk($sformatf("v%0d_sram_addr", idx), 32'(sram_addr), 32'(v.exp_saddr));
      chk($sformatf("v%0d_sram_wdata", idx), sram_wdata, v.exp_swdata);
    end
    @(negedge clk);
    chk($sformatf("v%0d_resp_vld", idx), 32'(u_if.resp_vld), 32'd1);
    chk($sformatf("v%0d_resp_err", idx), 32'(u_if.resp_err), 32'(v.exp_err));
    chk($sformatf("v%0d_resp_mtype", idx), 32'(u_if.resp_mtype), 32'(v.mtype));
    chk($sformatf("v%0d_resp_rdata", idx), u_if.resp_rdata, v.exp_rdata);
    $display("txn %0d: %s len=%0d addr=%h wdata=%h -> err=%0d rdata=%h",
             idx, v.mtype ? "WR" : "RD", v.len, v.addr, v.wdata,
             u_if.resp_err, u_if.resp_rdata);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //             mtype    len        addr          wdata         err  en  be     saddr     swdata        rdata
    vecs[0]  = '{DMEM_WR, DMEM_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 10'h004, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{DMEM_RD, DMEM_BYTE, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 4'h8, 10'h004, 32'h0,         32'h0000_00DE};
    vecs[2]  = '{DMEM_WR, DMEM_HALF, 32'h0000_0012, 32'h0000_ABCD, 1'b0, 1'b1, 4'hC, 10'h004, 32'hABCD_0000, 32'h0};
    vecs[3]  = '{DMEM_RD, DMEM_HALF, 32'h0000_0011, 32'h0,         1'b1, 1'b0, 4'h0, 10'h000, 32'h0,         32'h0};
    vecs[4]  = '{DMEM_RD, DMEM_WORD, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'hF, 10'h004, 32'h0,         32'hABCD_BEEF};
    vecs[5]  = '{DMEM_RD, DMEM_HALF, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 4'h3, 10'h004, 32'h0,         32'h0000_BEEF};
    vecs[6]  = '{DMEM_RD, DMEM_BYTE, 32'h0000_0011, 32'h0,         1'b0, 1'b1, 4'h2, 10'h004, 32'h0,         32'h0000_00BE};
    vecs[7]  = '{DMEM_RD, DMEM_WORD, 32'h0000_1000, 32'h0,         1'b1, 1'b0, 4'h0, 10'h000, 32'h0,         32'h0};
    vecs[8]  = '{DMEM_RD, 2'b11,     32'h0000_0010, 32'h0,         1'b1, 1'b0, 4'h0, 10'h000, 32'h0,         32'h0};
    vecs[9]  = '{DMEM_WR, DMEM_WORD, 32'h0000_0016, 32'h1111_1111, 1'b1, 1'b0, 4'h0, 10'h000, 32'h0,         32'h0};
    vecs[10] = '{DMEM_RD, DMEM_WORD, 32'h0000_0014, 32'h0,         1'b0, 1'b1, 4'hF, 10'h005, 32'h0,         32'h0};
    vecs[11] = '{DMEM_WR, DMEM_BYTE, 32'h0000_0017, 32'hFFFF_FF5A, 1'b0, 1'b1, 4'h8, 10'h005, 32'h5A00_0000, 32'h0};
    vecs[12] = '{DMEM_RD, DMEM_WORD, 32'h0000_0014, 32'h0,         1'b0, 1'b1, 4'hF, 10'h005, 32'h0,         32'h5A00_0000};
    vecs[13] = '{DMEM_WR, DMEM_WORD, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 1'b1, 4'hF, 10'h3FF, 32'hCAFE_F00D, 32'h0};
    vecs[14] = '{DMEM_RD, DMEM_HALF, 32'h0000_0FFE, 32'h0,         1'b0, 1'b1, 4'hC, 10'h3FF, 32'h0,         32'h0000_CAFE};

    rst = 1'b1;
    mem_clr = 1'b1;
    idle_req();
    u_if.resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 32'(u_if.req_rdy), 32'd1);
    chk("rst_resp_vld", 32'(u_if.resp_vld), 32'd0);
    chk("rst_resp_err", 32'(u_if.resp_err), 32'd0);
    chk("rst_resp_mtype", 32'(u_if.resp_mtype), 32'd0);
    chk("rst_resp_rdata", u_if.resp_rdata, 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_be", 32'(sram_be), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    rst = 1'b0;
    mem_clr = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Backpressure: response held five cycles while a second request waits,
    // then released with the waiting request accepted in the same cycle.
    @(negedge clk);
    u_if.resp_rdy = 1'b0;
    drive_req(DMEM_RD, DMEM_WORD, 32'h0000_0010, 32'h0);
    #1;
    chk("bp_req_rdy_idle", 32'(u_if.req_rdy), 32'd1);
    @(negedge clk);
    drive_req(DMEM_RD, DMEM_WORD, 32'h0000_0014, 32'h0);
    chk("bp_acc_req_rdy", 32'(u_if.req_rdy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_resp_vld", c), 32'(u_if.resp_vld), 32'd1);
      chk($sformatf("bp%0d_resp_rdata", c), u_if.resp_rdata, 32'hABCD_BEEF);
      chk($sformatf("bp%0d_resp_err", c), 32'(u_if.resp_err), 32'd0);
      chk($sformatf("bp%0d_req_rdy", c), 32'(u_if.req_rdy), 32'd0);
      chk($sformatf("bp%0d_sram_en", c), 32'(sram_en), 32'd0);
    end
    $display("txn bp: RD word 0x10 held 5 cycles rdata=%h", u_if.resp_rdata);
    u_if.resp_rdy = 1'b1;
    #1;
    chk("bp_release_req_rdy", 32'(u_if.req_rdy), 32'd1);
    @(negedge clk);
    idle_req();
    chk("b2b_sram_en", 32'(sram_en), 32'd1);
    chk("b2b_sram_addr", 32'(sram_addr), 32'h005);
    chk("b2b_resp_vld", 32'(u_if.resp_vld), 32'd0);
    @(negedge clk);
    chk("b2b_resp_vld2", 32'(u_if.resp_vld), 32'd1);
    chk("b2b_resp_rdata", u_if.resp_rdata, 32'h5A00_0000);
    $display("txn b2b: RD word 0x14 rdata=%h", u_if.resp_rdata);

    // Reset during the access cycle of a write: the write must not land.
    @(negedge clk);
    drive_req(DMEM_WR, DMEM_WORD, 32'h0000_0014, 32'h1234_5678);
    @(negedge clk);
    idle_req();
    rst = 1'b1;
    #1;
    chk("rstw_sram_en", 32'(sram_en), 32'd0);
    @(negedge clk);
    chk("rstw_resp_vld", 32'(u_if.resp_vld), 32'd0);
    chk("rstw_req_rdy", 32'(u_if.req_rdy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_resp_vld_after", 32'(u_if.resp_vld), 32'd0);
    $display("txn rst: WR word 0x14 dropped by reset");
    run_vec(99, '{DMEM_RD, DMEM_WORD, 32'h0000_0014, 32'h0, 1'b0, 1'b1, 4'hF, 10'h005, 32'h0, 32'h5A00_0000});

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory request interface. Accepts one request at a time, carried as a `dmem_req_ctrl_t` plus address and write data.
- Drives a single-port synchronous SRAM with 1-cycle read latency, handling byte-enables and lane alignment.
- Returns a response: aligned, zero-extended read data or a write ack, with an error flag.
- Sits between the core's load/store stage and the data SRAM macro.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the attached SRAM.
- BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- req_ctrl  input  4  `dmem_req_ctrl_t` {vld, mtype (0=read, 1=write), len}.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- req_rdy  output  1  request accepted when req_ctrl.vld && req_rdy.
- resp_vld  output  1  response valid.
- resp_rdy  input  1  response consumed when resp_vld && resp_rdy.
- resp_mtype  output  1  echo of request mtype.
- resp_err  output  1  misaligned, reserved len, or out-of-range.
- resp_rdata  output  32  load data, right-justified, zero-extended; 0 for writes and errors.
- sram_en  output  1  SRAM access strobe.
- sram_we  output  1  SRAM write enable.
- sram_be  output  4  byte enables.
- sram_addr  output  $clog2(DEPTH_WORDS)  word address.
- sram_wdata  output  32  lane-positioned write data.
- sram_rdata  input  32  read data, valid the cycle after sram_en && !sram_we.

Behaviour:
- Len encoding: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 reserved (error).
- Offset: off = addr[1:0].
- Error conditions (registered at accept):
  - misaligned: half with off[0]=1, or word with off≠0;
  - reserved len;
  - addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - req_rdy=1.
  - On accept, register ctrl, addr, wdata and err; go to ACCESS.
- ACCESS (exactly one cycle):
  - sram_en = !err.
  - sram_we = mtype.
  - sram_addr = (addr - BASE_ADDR) >> 2.
  - sram_be = mask(len) << off, where mask is 0001 / 0011 / 1111.
  - sram_wdata = wdata << (8*off).
  - Go to RESP.
- RESP:
  - resp_vld=1.
  - rdata is captured on entry from sram_rdata >> (8*off), masked to len. It is 0 if write or err.
  - Outputs hold stable while resp_rdy=0.
  - On handshake, go to IDLE, unless a new request is accepted in the same cycle (see next bullet).
- Back-to-back: req_rdy = (state==IDLE) || (state==RESP && resp_rdy). A request accepted during the completing RESP cycle goes directly to ACCESS.
- Latency: accept at cycle T → SRAM access at T+1 → resp_vld at T+2. Peak throughput is 1 request per 2 cycles.
- Outside ACCESS, all SRAM outputs are 0: sram_en, sram_we, sram_be, sram_addr and sram_wdata.
- Error requests never assert sram_en, but still take the same T+2 response timing.
- Reset values: req_rdy=1 after reset. resp_vld, resp_err, resp_mtype, resp_rdata and all sram_* outputs are 0.
- Reset mid-operation: any in-flight request is dropped without a response. A write in ACCESS at the reset cycle is suppressed, because sram_en is 0 the cycle rst is sampled high.
- req_ctrl.vld while req_rdy=0: ignored. The requester must hold the request until accepted.

Decomposition:
- Shared package additions:
  - dmem_len_e {DMEM_BYTE, DMEM_HALF, DMEM_WORD};
  - dmem_resp_t packed struct {vld, mtype, err, rdata[N_BITS-1:0]};
  - DMEM_RD = 1'b0, DMEM_WR = 1'b1.
- One natural combinational sub-module, dmem_lane_align. It computes be, shifted wdata, aligned/masked rdata and the misalign flag from len/off. It is reusable by a future cache.

Test Plan:
- Word write addr=0x10, wdata=0xDEADBEEF, len=WORD → at T+1 sram_en=1, we=1, be=4'hF, addr=4, wdata=0xDEADBEEF; at T+2 resp_vld=1, err=0, rdata=0.
- Byte read addr=0x13 with SRAM word 4 = 0xDEADBEEF → be=4'b1000; resp_rdata=0x000000DE at T+2.
- Half write addr=0x12, wdata=0x0000ABCD → be=4'b1100, sram_wdata=0xABCD0000. Half read addr=0x11 → resp_err=1, sram_en never asserted, rdata=0.
- Backpressure: hold resp_rdy=0 for 5 cycles → resp_vld, resp_rdata and resp_err stable, req_rdy=0. On resp_rdy=1 with a pending request, accept in the same cycle; its SRAM access follows next cycle.
- Out-of-range addr=BASE_ADDR+4*DEPTH_WORDS, and len=2'b11 → resp_err=1, no SRAM activity.
- Assert rst during ACCESS of a write → sram_en=0 that cycle, resp_vld stays 0, req_rdy=1 after reset, and a subsequent read of that address returns the old data.
